axi_read_error_responder: RTL and testbench

AXI_READ_ERROR_RESPONDER -- requirements
Module: axi_read_error_responder

---
 rtl/axi_node_pkg.sv | 21 ++
 rtl/axi_outstanding_counter.sv | 52 +++++
 rtl/axi_read_error_responder.sv | 148 ++++++++++++++
 tb/tb_axi_read_error_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// ---------------------------------------------------------------------------
// axi_node_pkg
// Types and constants shared by the AXI node blocks.
//   err_state_e : states of the read error responder
//   DECERR      : AXI RRESP/BRESP encoding for a decode error
//   beat_len_t  : 8-bit AXI burst length / beat index
// ---------------------------------------------------------------------------
package axi_node_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } err_state_e;

    localparam logic [1:0] DECERR = 2'b11;

    typedef logic [7:0] beat_len_t;

endpackage : axi_node_pkg

// File: rtl/axi_outstanding_counter.sv
// ---------------------------------------------------------------------------
// axi_outstanding_counter
// Saturating up/down counter that tracks routed read transactions whose
// last R beat has not yet been delivered.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc_i       : +1 (ignored at the maximum)
//   dec_i       : -1 (ignored at zero)
//   full_o      : counter equals 2^CNT_WIDTH-1
//   nonzero_o   : counter is non-zero
// inc_i and dec_i together leave the count unchanged.
// ---------------------------------------------------------------------------
module axi_outstanding_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic nonzero_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o    = (cnt_q == CNT_MAX);
    assign nonzero_o = (cnt_q != '0);

endmodule : axi_outstanding_counter

// File: rtl/axi_read_error_responder.sv
// ---------------------------------------------------------------------------
// axi_read_error_responder
// Generates a DECERR read burst for an AR that decoded to no slave. The AR
// info is captured on sample_ardata_info_i; the responder then waits until
// every routed read still in flight has returned its last beat (so R
// ordering per master is preserved) and emits arlen+1 DECERR beats.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   sample_ardata_info_i       : capture arid/arlen/aruser (IDLE only)
//   arid_i, arlen_i, aruser_i  : AR info of the current request
//   incr_req_i                 : a routed AR was accepted
//   rvalid_i, rready_i, rlast_i: slave-side R handshake (observed only)
//   full_counter_o             : outstanding counter at its maximum
//   outstanding_trans_o        : outstanding counter non-zero
//   error_gnt_o                : one-cycle pulse after the error burst
//   err_rvalid_o, err_rready_i : error R handshake
//   err_r*_o                   : error R payload
// ---------------------------------------------------------------------------
module axi_read_error_responder
    import axi_node_pkg::*;
#(
    parameter int AXI_ID    = 6,
    parameter int AXI_USER  = 6,
    parameter int AXI_DATA  = 64,
    parameter int CNT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_ardata_info_i,
    input  logic [AXI_ID-1:0]   arid_i,
    input  logic [7:0]          arlen_i,
    input  logic [AXI_USER-1:0] aruser_i,
    input  logic                incr_req_i,
    input  logic                rvalid_i,
    input  logic                rready_i,
    input  logic                rlast_i,
    output logic                full_counter_o,
    output logic                outstanding_trans_o,
    output logic                error_gnt_o,
    output logic                err_rvalid_o,
    input  logic                err_rready_i,
    output logic [AXI_ID-1:0]   err_rid_o,
    output logic [AXI_DATA-1:0] err_rdata_o,
    output logic [1:0]          err_rresp_o,
    output logic                err_rlast_o,
    output logic [AXI_USER-1:0] err_ruser_o
);

    err_state_e            state_q, state_d;
    beat_len_t             beat_cnt_q, beat_cnt_d;
    beat_len_t             arlen_q, arlen_d;
    logic [AXI_ID-1:0]     arid_q, arid_d;
    logic [AXI_USER-1:0]   aruser_q, aruser_d;

    logic                  cnt_nonzero;
    logic                  last_beat;

    // Outstanding routed reads: retire only on the final beat of a burst.
    axi_outstanding_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_outstanding_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (incr_req_i),
        .dec_i     (rvalid_i & rready_i & rlast_i),
        .full_o    (full_counter_o),
        .nonzero_o (cnt_nonzero)
    );

    assign outstanding_trans_o = cnt_nonzero;

    assign last_beat = (beat_cnt_q == arlen_q);

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        arid_d       = arid_q;
        arlen_d      = arlen_q;
        aruser_d     = aruser_q;
        err_rvalid_o = 1'b0;
        err_rlast_o  = 1'b0;
        error_gnt_o  = 1'b0;

        case (state_q)
            IDLE: begin
                // AR info is captured only here, so a stray sample pulse
                // later in the sequence cannot corrupt the pending burst.
                if (sample_ardata_info_i) begin
                    arid_d     = arid_i;
                    arlen_d    = arlen_i;
                    aruser_d   = aruser_i;
                    beat_cnt_d = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // Uses the registered count: with nothing outstanding on
                // entry, DRAIN lasts exactly one cycle.
                if (!cnt_nonzero) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // Payload comes straight from registers that move only on a
                // handshake, so it is stable while err_rready_i is low.
                err_rvalid_o = 1'b1;
                err_rlast_o  = last_beat;
                if (err_rready_i) begin
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        // Held on the last beat so arlen=255 never wraps.
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                error_gnt_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            arid_q     <= '0;
            arlen_q    <= '0;
            aruser_q   <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            arid_q     <= arid_d;
            arlen_q    <= arlen_d;
            aruser_q   <= aruser_d;
        end
    end

    assign err_rid_o   = arid_q;
    assign err_ruser_o = aruser_q;
    assign err_rdata_o = '0;
    assign err_rresp_o = DECERR;

endmodule : axi_read_error_responder

// File: tb/tb_axi_read_error_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_read_error_responder
// Directed self-checking bench for axi_read_error_responder (default params).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_axi_read_error_responder;

    localparam int AXI_ID    = 6;
    localparam int AXI_USER  = 6;
    localparam int AXI_DATA  = 64;
    localparam int CNT_WIDTH = 4;

    logic                clk;
    logic                rst_n;
    logic                sample_ardata_info_i;
    logic [AXI_ID-1:0]   arid_i;
    logic [7:0]          arlen_i;
    logic [AXI_USER-1:0] aruser_i;
    logic                incr_req_i;
    logic                rvalid_i;
    logic                rready_i;
    logic                rlast_i;
    logic                full_counter_o;
    logic                outstanding_trans_o;
    logic                error_gnt_o;
    logic                err_rvalid_o;
    logic                err_rready_i;
    logic [AXI_ID-1:0]   err_rid_o;
    logic [AXI_DATA-1:0] err_rdata_o;
    logic [1:0]          err_rresp_o;
    logic                err_rlast_o;
    logic [AXI_USER-1:0] err_ruser_o;

    int checks = 0;
    int errors = 0;

    axi_read_error_responder #(
        .AXI_ID    (AXI_ID),
        .AXI_USER  (AXI_USER),
        .AXI_DATA  (AXI_DATA),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sample_ardata_info_i (sample_ardata_info_i),
        .arid_i               (arid_i),
        .arlen_i              (arlen_i),
        .aruser_i             (aruser_i),
        .incr_req_i           (incr_req_i),
        .rvalid_i             (rvalid_i),
        .rready_i             (rready_i),
        .rlast_i              (rlast_i),
        .full_counter_o       (full_counter_o),
        .outstanding_trans_o  (outstanding_trans_o),
        .error_gnt_o          (error_gnt_o),
        .err_rvalid_o         (err_rvalid_o),
        .err_rready_i         (err_rready_i),
        .err_rid_o            (err_rid_o),
        .err_rdata_o          (err_rdata_o),
        .err_rresp_o          (err_rresp_o),
        .err_rlast_o          (err_rlast_o),
        .err_ruser_o          (err_ruser_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave-side last-beat handshake (decrements the outstanding count).
    task automatic set_rlast_hs(input logic v);
        rvalid_i = v;
        rready_i = v;
        rlast_i  = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, 64'(err_rvalid_o), 64'd0);
        check({tag, "_rlast"},  64'(err_rlast_o),  64'd0);
        check({tag, "_gnt"},    64'(error_gnt_o),  64'd0);
        check({tag, "_rid"},    64'(err_rid_o),    64'd0);
        check({tag, "_ruser"},  64'(err_ruser_o),  64'd0);
        check({tag, "_rdata"},  err_rdata_o,       64'd0);
        check({tag, "_rresp"},  64'(err_rresp_o),  64'd3);
        check({tag, "_full"},   64'(full_counter_o), 64'd0);
        check({tag, "_outst"},  64'(outstanding_trans_o), 64'd0);
    endtask

    initial begin
        int hs;
        int gnt_cnt;
        logic pat [4];

        rst_n                = 1'b0;
        sample_ardata_info_i = 1'b0;
        arid_i               = '0;
        arlen_i              = '0;
        aruser_i             = '0;
        incr_req_i           = 1'b0;
        err_rready_i         = 1'b0;
        set_rlast_hs(1'b0);

        // Reset state
        step();
        step();
        check_reset_outputs("rst");
        #3 rst_n = 1'b1;
        step();

        // Single-beat DECERR with nothing outstanding
        arid_i = 6'd5; arlen_i = 8'd0; aruser_i = 6'h11;
        err_rready_i = 1'b1;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        check("t1_drain_rvalid", 64'(err_rvalid_o), 64'd0);
        step();
        check("t1_rvalid", 64'(err_rvalid_o), 64'd1);
        check("t1_rid",    64'(err_rid_o),    64'd5);
        check("t1_ruser",  64'(err_ruser_o),  64'h11);
        check("t1_rlast",  64'(err_rlast_o),  64'd1);
        check("t1_rdata",  err_rdata_o,       64'd0);
        check("t1_rresp",  64'(err_rresp_o),  64'd3);
        step();
        check("t1_gnt",        64'(error_gnt_o),  64'd1);
        check("t1_done_rvalid", 64'(err_rvalid_o), 64'd0);
        step();
        check("t1_gnt_off", 64'(error_gnt_o), 64'd0);

        // Wait for 3 outstanding reads, then a 4-beat burst
        incr_req_i = 1'b1;
        repeat (3) step();
        incr_req_i = 1'b0;
        check("t2_outst", 64'(outstanding_trans_o), 64'd1);
        check("t2_full",  64'(full_counter_o),      64'd0);
        arid_i = 6'd9; arlen_i = 8'd3; aruser_i = 6'h2a;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_wait_rvalid", 64'(err_rvalid_o), 64'd0);
            step();
        end
        // Sample while busy must not disturb the captured info
        arid_i = 6'h3f; aruser_i = 6'h01; arlen_i = 8'd0;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        // Non-last R handshake does not retire anything
        rvalid_i = 1'b1; rready_i = 1'b1; rlast_i = 1'b0;
        step();
        set_rlast_hs(1'b1);
        step();
        step();
        check("t2_outst_1left", 64'(outstanding_trans_o), 64'd1);
        check("t2_hold_rvalid", 64'(err_rvalid_o), 64'd0);
        step();
        set_rlast_hs(1'b0);
        check("t2_outst_zero",  64'(outstanding_trans_o), 64'd0);
        check("t2_drain_rvalid", 64'(err_rvalid_o), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("t2_rvalid", 64'(err_rvalid_o), 64'd1);
            check("t2_rid",    64'(err_rid_o),    64'd9);
            check("t2_ruser",  64'(err_ruser_o),  64'h2a);
            check("t2_rlast",  64'(err_rlast_o),  (i == 3) ? 64'd1 : 64'd0);
            step();
        end
        check("t2_gnt", 64'(error_gnt_o), 64'd1);
        step();

        // 4-beat burst with err_rready 1-0-0-1 back-pressure
        arid_i = 6'h21; arlen_i = 8'd3; aruser_i = 6'h15;
        err_rready_i = 1'b0;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        step();
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        hs = 0;
        gnt_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (hs < 4) begin
                check("t3_rvalid", 64'(err_rvalid_o), 64'd1);
                check("t3_rid",    64'(err_rid_o),    64'h21);
                check("t3_ruser",  64'(err_ruser_o),  64'h15);
                check("t3_rlast",  64'(err_rlast_o),  (hs == 3) ? 64'd1 : 64'd0);
            end else begin
                check("t3_after_rvalid", 64'(err_rvalid_o), 64'd0);
            end
            if (error_gnt_o) gnt_cnt++;
            err_rready_i = pat[k % 4];
            if (err_rvalid_o && err_rready_i) hs++;
            step();
        end
        err_rready_i = 1'b0;
        check("t3_handshakes", 64'(hs), 64'd4);
        check("t3_gnt_pulses", 64'(gnt_cnt), 64'd1);

        // Simultaneous increment and retire at count 2
        incr_req_i = 1'b1;
        step();
        step();
        set_rlast_hs(1'b1);
        step();
        incr_req_i = 1'b0;
        check("t4_simul_outst", 64'(outstanding_trans_o), 64'd1);
        step();
        check("t4_dec1_outst", 64'(outstanding_trans_o), 64'd1);
        step();
        set_rlast_hs(1'b0);
        check("t4_dec2_outst", 64'(outstanding_trans_o), 64'd0);

        // Saturation at 15 and at 0
        incr_req_i = 1'b1;
        repeat (14) step();
        check("t5_14_full", 64'(full_counter_o), 64'd0);
        step();
        check("t5_15_full", 64'(full_counter_o), 64'd1);
        step();
        incr_req_i = 1'b0;
        check("t5_16_full",  64'(full_counter_o),      64'd1);
        check("t5_16_outst", 64'(outstanding_trans_o), 64'd1);
        set_rlast_hs(1'b1);
        step();
        check("t5_14_again_full", 64'(full_counter_o), 64'd0);
        repeat (13) step();
        check("t5_1_outst", 64'(outstanding_trans_o), 64'd1);
        step();
        check("t5_0_outst", 64'(outstanding_trans_o), 64'd0);
        step();
        set_rlast_hs(1'b0);
        check("t5_under_outst", 64'(outstanding_trans_o), 64'd0);
        check("t5_under_full",  64'(full_counter_o),      64'd0);
        incr_req_i = 1'b1;
        step();
        incr_req_i = 1'b0;
        check("t5_reinc_outst", 64'(outstanding_trans_o), 64'd1);
        set_rlast_hs(1'b1);
        step();
        set_rlast_hs(1'b0);
        check("t5_redec_outst", 64'(outstanding_trans_o), 64'd0);

        // Reset during beat 2 of an 8-beat burst
        arid_i = 6'd3; arlen_i = 8'd7; aruser_i = 6'h07;
        err_rready_i = 1'b1;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        step();
        step();
        step();
        check("t6_beat2_rvalid", 64'(err_rvalid_o), 64'd1);
        check("t6_beat2_rlast",  64'(err_rlast_o),  64'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_gnt",    64'(error_gnt_o),  64'd0);
            check("t6_no_rvalid", 64'(err_rvalid_o), 64'd0);
        end
        // Clean 2-beat burst after the abort
        arid_i = 6'h11; arlen_i = 8'd1; aruser_i = 6'h03;
        sample_ardata_info_i = 1'b1;
        step();
        sample_ardata_info_i = 1'b0;
        step();
        check("t6_b0_rvalid", 64'(err_rvalid_o), 64'd1);
        check("t6_b0_rid",    64'(err_rid_o),    64'h11);
        check("t6_b0_rlast",  64'(err_rlast_o),  64'd0);
        step();
        check("t6_b1_rlast",  64'(err_rlast_o),  64'd1);
        check("t6_b1_ruser",  64'(err_ruser_o),  64'h03);
        step();
        check("t6_gnt", 64'(error_gnt_o), 64'd1);
        step();
        check("t6_gnt_off", 64'(error_gnt_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_read_error_responder
